// File: rtl/pc_stack_unit.sv
// pc_stack_unit: fetch-stage program counter with relative jumps, call/return
// through an internal return-address stack, sticky stack error flags and a
// valid/ready fetch request toward instruction memory.
//
// Handshake semantics (both sides):
//   - Command side: the control unit presents PCDrive/PCSet and holds them
//     until CmdReady is high at a rising edge; a non-HOLD code present at that
//     edge is consumed exactly once. CmdReady = !GetInstruction | FetchReady.
//   - Fetch side: GetInstruction is the valid for PCAddr. Once raised, both
//     stay stable until FetchReady is high at a rising edge. A command accepted
//     at that same edge re-raises the request for the new address with no
//     idle cycle in between.
module pc_stack_unit #(
    parameter int              ADDR_W      = 32,
    parameter int              STEP        = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int              STACK_DEPTH = 8,
    parameter int              SP_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCSet,
    input  logic [2:0]        PCDrive,
    output logic              CmdReady,
    output logic [ADDR_W-1:0] PCAddr,
    output logic              GetInstruction,
    input  logic              FetchReady,
    output logic [SP_W-1:0]   StackLevel,
    output logic              StackOverflow,
    output logic              StackUnderflow
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] CMD_HOLD = 3'b000;
    localparam logic [2:0] CMD_INC  = 3'b001;
    localparam logic [2:0] CMD_REL  = 3'b010;
    localparam logic [2:0] CMD_SET  = 3'b011;
    localparam logic [2:0] CMD_CALL = 3'b100;
    localparam logic [2:0] CMD_RET  = 3'b101;
    localparam logic [2:0] CMD_VEC  = 3'b110;
    localparam logic [2:0] CMD_RSVD = 3'b111;

    // Request FSM: the state bit is driven straight out as GetInstruction,
    // so the FSM state is always visible at the port.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

    req_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic              cmd_ready;
    logic              cmd_valid;
    logic              accept;
    logic              raise_req;
    logic              push_en;
    logic              stack_full;
    logic              stack_empty;
    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;

    assign cmd_ready   = (state_q == ST_IDLE) | FetchReady;
    assign cmd_valid   = (PCDrive != CMD_HOLD) && (PCDrive != CMD_RSVD);
    assign accept      = cmd_ready & cmd_valid;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign pc_inc      = pc_q + ADDR_W'(STEP);
    assign sp_dec      = sp_q - SP_W'(1);
    // sp_q indexes the next free slot; sp_q-1 is the top entry.
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_dec[IDX_W-1:0];

    // Datapath: next PC, stack pointer and sticky flags for an accepted command.
    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        raise_req = 1'b0;
        if (accept) begin
            raise_req = 1'b1;
            case (PCDrive)
                CMD_INC: pc_d = pc_inc;
                // Two's-complement add: a negative offset wraps to the same result.
                CMD_REL: pc_d = pc_q + PCSet;
                CMD_SET: pc_d = PCSet;
                CMD_CALL: begin
                    pc_d = PCSet;
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end
                end
                CMD_RET: begin
                    if (stack_empty) begin
                        unf_d     = 1'b1;
                        raise_req = 1'b0;
                    end else begin
                        pc_d = stack_mem[pop_idx];
                        sp_d = sp_dec;
                    end
                end
                CMD_VEC: begin
                    pc_d = RESET_ADDR;
                    sp_d = '0;
                end
                default: raise_req = 1'b0;
            endcase
        end
    end

    // Request FSM next state: a new request wins over retiring the current one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (raise_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (raise_req)       state_d = ST_REQ;
                else if (FetchReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_ADDR;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset, so no reset.
    always_ff @(posedge clk) begin
        if (push_en && rst) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign CmdReady       = cmd_ready;
    assign PCAddr         = pc_q;
    assign GetInstruction = (state_q == ST_REQ);
    assign StackLevel     = sp_q;
    assign StackOverflow  = ovf_q;
    assign StackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed bench for pc_stack_unit. A reference model
// predicts PC, stack level and flags per command; each predicted fetch
// address is queued and compared when the DUT completes the fetch handshake.
module tb_pc_stack_unit;

    localparam int ADDR_W = 32;
    localparam int SP_W   = 4;
    localparam int DEPTH  = 8;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] INC  = 3'b001;
    localparam logic [2:0] REL  = 3'b010;
    localparam logic [2:0] SET  = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;
    localparam logic [2:0] VEC  = 3'b110;
    localparam logic [2:0] RSVD = 3'b111;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] PCSet      = '0;
    logic [2:0]        PCDrive    = HOLD;
    logic              FetchReady = 1'b1;
    logic              CmdReady;
    logic [ADDR_W-1:0] PCAddr;
    logic              GetInstruction;
    logic [SP_W-1:0]   StackLevel;
    logic              StackOverflow;
    logic              StackUnderflow;

    pc_stack_unit #(
        .ADDR_W(ADDR_W), .STEP(1), .RESET_ADDR('0), .STACK_DEPTH(DEPTH), .SP_W(SP_W)
    ) dut (
        .clk(clk), .rst(rst), .PCSet(PCSet), .PCDrive(PCDrive), .CmdReady(CmdReady),
        .PCAddr(PCAddr), .GetInstruction(GetInstruction), .FetchReady(FetchReady),
        .StackLevel(StackLevel), .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference model
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_stk [DEPTH];
    int                m_lvl;
    logic              m_ovf;
    logic              m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc  = '0;
        m_lvl = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Driver: present one command, wait for acceptance, update the model.
    task automatic issue(input logic [2:0] cmd, input logic [31:0] val);
        int   n;
        logic push;
        PCDrive = cmd;
        PCSet   = val;
        n = 0;
        while (CmdReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("cmd_ready_timeout", {31'b0, CmdReady}, 32'd1);
        push = 1'b1;
        case (cmd)
            INC: m_pc = m_pc + 32'd1;
            REL: m_pc = m_pc + val;
            SET: m_pc = val;
            CALL: begin
                if (m_lvl < DEPTH) begin
                    m_stk[m_lvl] = m_pc + 32'd1;
                    m_lvl++;
                end else begin
                    m_ovf = 1'b1;
                end
                m_pc = val;
            end
            RET: begin
                if (m_lvl == 0) begin
                    m_unf = 1'b1;
                    push  = 1'b0;
                end else begin
                    m_lvl--;
                    m_pc = m_stk[m_lvl];
                end
            end
            VEC: begin
                m_pc  = '0;
                m_lvl = 0;
            end
            default: push = 1'b0;
        endcase
        if (push) exp_q.push_back(m_pc);
        tick();
        PCDrive = HOLD;
        chk("cmd_pc", PCAddr, m_pc);
        chk("cmd_level", 32'(StackLevel), 32'(m_lvl));
        chk("cmd_ovf", {31'b0, StackOverflow}, {31'b0, m_ovf});
        chk("cmd_unf", {31'b0, StackUnderflow}, {31'b0, m_unf});
        chk("cmd_getinstr", {31'b0, GetInstruction}, {31'b0, push});
    endtask

    // Monitor: pop and compare at each completed fetch handshake.
    always @(negedge clk) begin
        if (rst && GetInstruction && FetchReady) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL fetch_unexpected: observed PCAddr=%0h expected no request", PCAddr);
            end
            if (exp_q.size() > 0) chk("fetch_addr", PCAddr, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // 1. reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_pc", PCAddr, 32'd0);
        chk("rst_getinstr", {31'b0, GetInstruction}, 32'd0);
        chk("rst_level", 32'(StackLevel), 32'd0);
        chk("rst_ovf", {31'b0, StackOverflow}, 32'd0);
        chk("rst_unf", {31'b0, StackUnderflow}, 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_getinstr", {31'b0, GetInstruction}, 32'd0);

        // 2. SET then back-to-back INCs
        issue(SET, 32'd5791);
        chk("set_5791", PCAddr, 32'd5791);
        issue(INC, 32'd0);
        chk("inc_5792", PCAddr, 32'd5792);
        issue(INC, 32'd0);
        chk("inc_5793", PCAddr, 32'd5793);

        // 3. negative relative jump and wrap-around
        issue(SET, 32'd7894);
        issue(REL, 32'hFFFF_FFF6);
        chk("rel_minus10", PCAddr, 32'd7884);
        issue(SET, 32'hFFFF_FFFF);
        issue(INC, 32'd0);
        chk("inc_wrap", PCAddr, 32'd0);

        // 4. single call/return
        issue(SET, 32'd100);
        issue(CALL, 32'd33);
        chk("call_pc", PCAddr, 32'd33);
        chk("call_level", 32'(StackLevel), 32'd1);
        issue(RET, 32'd0);
        chk("ret_pc", PCAddr, 32'd101);
        chk("ret_level", 32'(StackLevel), 32'd0);

        // 5. overflow then underflow
        issue(SET, 32'd101);
        for (int i = 0; i < 9; i++) issue(CALL, 32'h1000 + 32'(i) * 32'h10);
        chk("ovf_level", 32'(StackLevel), 32'd8);
        chk("ovf_flag", {31'b0, StackOverflow}, 32'd1);
        chk("ovf_pc", PCAddr, 32'h1080);
        for (int i = 0; i < 9; i++) issue(RET, 32'd0);
        chk("unf_flag", {31'b0, StackUnderflow}, 32'd1);
        chk("unf_pc", PCAddr, 32'd102);
        chk("unf_getinstr", {31'b0, GetInstruction}, 32'd0);

        // VEC keeps sticky flags; reserved code behaves as HOLD
        issue(CALL, 32'd500);
        issue(VEC, 32'd77);
        chk("vec_pc", PCAddr, 32'd0);
        chk("vec_level", 32'(StackLevel), 32'd0);
        chk("vec_ovf_kept", {31'b0, StackOverflow}, 32'd1);
        issue(RSVD, 32'd55);
        chk("rsvd_pc", PCAddr, 32'd0);
        tick();
        chk("hold_idle_pc", PCAddr, 32'd0);
        chk("hold_idle_getinstr", {31'b0, GetInstruction}, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // 6. stall with INC held, then reset mid-stall
        issue(INC, 32'd0);
        FetchReady = 1'b0;
        PCDrive    = INC;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PCAddr, 32'd1);
            chk("stall_getinstr", {31'b0, GetInstruction}, 32'd1);
            chk("stall_cmdready", {31'b0, CmdReady}, 32'd0);
        end
        rst = 1'b0;
        tick();
        PCDrive = HOLD;
        chk("stall_rst_pc", PCAddr, 32'd0);
        chk("stall_rst_getinstr", {31'b0, GetInstruction}, 32'd0);
        chk("stall_rst_ovf", {31'b0, StackOverflow}, 32'd0);
        rst = 1'b1;
        model_reset();

        // recovery after reset
        FetchReady = 1'b1;
        issue(SET, 32'd42);
        tick();
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
